ili9341_if_axil_regs: RTL and testbench

- AXI4-Lite responder (slave) terminating the S00_AXI port of the ili9341_if core.
- Holds NUM_REGS 32-bit read/write control registers and exposes them to the display engine.
- Generates a one-cycle commit strobe per register write.
- It is the target that the AXI master VIP drives in the bfm_design example: sequential writes of 1..4 to 0x0/0x4/0x8/0xC, then read-back compare.

---
 rtl/ili9341_if_axil_regs.sv | 188 ++++++++++++++++++
 tb/tb_ili9341_if_axil_regs.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ili9341_if_axil_regs.sv
// AXI4-Lite register file for the ili9341_if core: NUM_REGS 32-bit control
// registers with byte strobes, a flattened register view for the display
// engine and a one-cycle write-commit pulse per register.
module ili9341_if_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                                     s00_axi_aclk,
    input  logic                                     s00_axi_areset,
    // write address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            s00_axi_awaddr,
    input  logic [2:0]                               s00_axi_awprot,
    input  logic                                     s00_axi_awvalid,
    output logic                                     s00_axi_awready,
    // write data channel
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          s00_axi_wstrb,
    input  logic                                     s00_axi_wvalid,
    output logic                                     s00_axi_wready,
    // write response channel
    output logic [1:0]                               s00_axi_bresp,
    output logic                                     s00_axi_bvalid,
    input  logic                                     s00_axi_bready,
    // read address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            s00_axi_araddr,
    input  logic [2:0]                               s00_axi_arprot,
    input  logic                                     s00_axi_arvalid,
    output logic                                     s00_axi_arready,
    // read data channel
    output logic [C_S_AXI_DATA_WIDTH-1:0]            s00_axi_rdata,
    output logic [1:0]                               s00_axi_rresp,
    output logic                                     s00_axi_rvalid,
    input  logic                                     s00_axi_rready,
    // register view for the display engine
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0]   reg_q,
    output logic [NUM_REGS-1:0]                      reg_wr_pulse
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int NB    = DW / 8;
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

    // Protection bits and the byte offset inside a word carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // State registers and their next-state values
    logic             aw_held_q, aw_held_d;
    logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
    logic             w_held_q, w_held_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [NB-1:0]    wstrb_q, wstrb_d;
    logic             bvalid_q, bvalid_d;
    logic             ar_pending_q, ar_pending_d;
    logic [DW-1:0]    rbuf_q, rbuf_d;
    logic             rvalid_q, rvalid_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [NUM_REGS-1:0] pulse_q, pulse_d;
    logic [DW-1:0]    regs_q [NUM_REGS];
    logic [DW-1:0]    regs_d [NUM_REGS];

    logic             aw_hs, w_hs, ar_hs, commit;
    logic [DW-1:0]    wmask;
    logic [IDX_W-1:0] ar_idx;

    // Ready is forced low while reset is asserted, including the very first
    // cycle after an asynchronous reset lands mid-cycle.
    assign s00_axi_awready = !s00_axi_areset && !aw_held_q && !bvalid_q;
    assign s00_axi_wready  = !s00_axi_areset && !w_held_q && !bvalid_q;
    assign s00_axi_arready = !s00_axi_areset && !rvalid_q && !ar_pending_q;

    assign aw_hs  = s00_axi_awvalid && s00_axi_awready;
    assign w_hs   = s00_axi_wvalid && s00_axi_wready;
    assign ar_hs  = s00_axi_arvalid && s00_axi_arready;
    // Both halves of a write are latched first; commit happens one edge later.
    assign commit = aw_held_q && w_held_q;
    assign ar_idx = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

    assign s00_axi_bresp  = 2'b00;
    assign s00_axi_rresp  = 2'b00;
    assign s00_axi_bvalid = bvalid_q;
    assign s00_axi_rvalid = rvalid_q;
    assign s00_axi_rdata  = rdata_q;
    assign reg_wr_pulse   = pulse_q;

    genvar gi;

    // Byte-enable expansion of the latched strobe
    for (gi = 0; gi < NB; gi++) begin : g_mask
        assign wmask[8*gi +: 8] = {8{wstrb_q[gi]}};
    end

    // Flattened register view, reg i at bits [32i+31:32i]
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign reg_q[DW*gi +: DW] = regs_q[gi];
    end

    // Next-state logic for both write and read paths
    always_comb begin
        aw_held_d    = aw_held_q;
        aw_idx_d     = aw_idx_q;
        w_held_d     = w_held_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        bvalid_d     = bvalid_q;
        ar_pending_d = ar_pending_q;
        rbuf_d       = rbuf_q;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;
        pulse_d      = '0;
        regs_d       = regs_q;

        // write: latch each channel independently
        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s00_axi_wdata;
            wstrb_d  = s00_axi_wstrb;
        end

        // write: retire the response, then commit (commit cannot overlap bvalid)
        if (bvalid_q && s00_axi_bready) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            regs_d[aw_idx_q]  = (regs_q[aw_idx_q] & ~wmask) | (wdata_q & wmask);
            pulse_d[aw_idx_q] = 1'b1;
            bvalid_d          = 1'b1;
            aw_held_d         = 1'b0;
            w_held_d          = 1'b0;
        end

        // read: sample the register on the AR edge so a write committing on
        // that same edge stays invisible, present it one edge later
        if (ar_hs) begin
            ar_pending_d = 1'b1;
            rbuf_d       = regs_q[ar_idx];
        end
        if (ar_pending_q) begin
            ar_pending_d = 1'b0;
            rvalid_d     = 1'b1;
            rdata_d      = rbuf_q;
        end else if (rvalid_q && s00_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // State register with asynchronous reset; reset abandons any transaction
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            aw_held_q    <= 1'b0;
            aw_idx_q     <= '0;
            w_held_q     <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            bvalid_q     <= 1'b0;
            ar_pending_q <= 1'b0;
            rbuf_q       <= '0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            pulse_q      <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            aw_held_q    <= aw_held_d;
            aw_idx_q     <= aw_idx_d;
            w_held_q     <= w_held_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            bvalid_q     <= bvalid_d;
            ar_pending_q <= ar_pending_d;
            rbuf_q       <= rbuf_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            pulse_q      <= pulse_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_ili9341_if_axil_regs.sv
// Directed testbench for ili9341_if_axil_regs with a read-data scoreboard
// and a spec-level register model.
module tb_ili9341_if_axil_regs;

    logic         clk;
    logic         rst;
    logic [3:0]   awaddr;
    logic         awvalid, awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid, wready;
    logic [1:0]   bresp;
    logic         bvalid, bready;
    logic [3:0]   araddr;
    logic         arvalid, arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid, rready;
    logic [127:0] reg_q;
    logic [3:0]   reg_wr_pulse;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [4];
    logic [31:0] exp_rd_q [$];
    int pulse_cnt [4];
    int exp_pulse [4];
    int b_cnt = 0;
    int exp_b = 0;
    logic bv_prev = 1'b0;

    ili9341_if_axil_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4),
        .NUM_REGS(4)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (rst),
        .s00_axi_awaddr (awaddr),
        .s00_axi_awprot (3'b000),
        .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata  (wdata),
        .s00_axi_wstrb  (wstrb),
        .s00_axi_wvalid (wvalid),
        .s00_axi_wready (wready),
        .s00_axi_bresp  (bresp),
        .s00_axi_bvalid (bvalid),
        .s00_axi_bready (bready),
        .s00_axi_araddr (araddr),
        .s00_axi_arprot (3'b000),
        .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata  (rdata),
        .s00_axi_rresp  (rresp),
        .s00_axi_rvalid (rvalid),
        .s00_axi_rready (rready),
        .reg_q          (reg_q),
        .reg_wr_pulse   (reg_wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled 2 ns after each rising edge
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 4; i++) begin
            if (reg_wr_pulse[i]) pulse_cnt[i]++;
        end
        if (bvalid && !bv_prev) b_cnt++;
        bv_prev = bvalid;
    end

    initial begin
        #500us;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    task automatic check_counts(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_pulse%0d", tag, i), pulse_cnt[i], exp_pulse[i]);
        end
        check($sformatf("%s_bcount", tag), b_cnt, exp_b);
    endtask

    // Drive AW and W with independent start delays; updates the model on acceptance.
    task automatic send_wr(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly);
        bit aw_done, w_done, aw_f, w_f;
        int idx;
        aw_done = 0;
        w_done  = 0;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
            awvalid = !aw_done && (c >= aw_dly);
            wvalid  = !w_done && (c >= w_dly);
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            @(negedge clk);
            if (aw_f) aw_done = 1;
            if (w_f)  w_done  = 1;
        end
        awvalid = 0;
        wvalid  = 0;
        check($sformatf("wr_accept_%h", addr), {aw_done, w_done}, 2'b11);
        idx = int'(addr[3:2]);
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
        end
        exp_b++;
        exp_pulse[idx]++;
    endtask

    task automatic wait_b();
        bit got;
        got = 0;
        bready = 1;
        for (int i = 0; i < 40 && !got; i++) begin
            if (bvalid) begin
                got = 1;
                check("bresp", bresp, 2'b00);
                $display("B    bresp=%0d reg_q=%h", bresp, reg_q);
            end
            @(negedge clk);
        end
        bready = 0;
        check("b_seen", got, 1);
    endtask

    task automatic send_ar(input logic [3:0] addr, input logic [31:0] exp);
        bit done;
        done = 0;
        exp_rd_q.push_back(exp);
        araddr  = addr;
        arvalid = 1;
        for (int i = 0; i < 40 && !done; i++) begin
            if (arready) done = 1;
            @(negedge clk);
        end
        arvalid = 0;
        check($sformatf("ar_accept_%h", addr), done, 1);
    endtask

    task automatic wait_r();
        bit got;
        logic [31:0] e;
        got = 0;
        rready = 1;
        for (int i = 0; i < 40 && !got; i++) begin
            if (rvalid) begin
                got = 1;
                check("rd_queue_size", exp_rd_q.size(), 1);
                if (exp_rd_q.size() > 0) begin
                    e = exp_rd_q.pop_front();
                    check("rdata", rdata, e);
                    check("rresp", rresp, 2'b00);
                    $display("R    rdata=%h expected=%h rresp=%0d", rdata, e, rresp);
                end
            end
            @(negedge clk);
        end
        rready = 0;
        check("r_seen", got, 1);
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        send_wr(addr, data, strb, 0, 0);
        wait_b();
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
        send_ar(addr, exp);
        wait_r();
    endtask

    logic [31:0] hold;
    bit seen;

    initial begin
        rst = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
        bready = 0; araddr = 0; arvalid = 0; rready = 0;
        for (int i = 0; i < 4; i++) begin
            model[i] = 0; pulse_cnt[i] = 0; exp_pulse[i] = 0;
        end

        // ---- reset values ----
        repeat (10) @(negedge clk);
        check("rst_hs", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_reg_q", reg_q, 128'h0);
        check("rst_pulse", reg_wr_pulse, 4'h0);
        repeat (10) @(negedge clk);
        rst = 0;
        @(negedge clk);
        for (int a = 0; a < 4; a++) axi_read(4'(a * 4), 32'h0);

        // ---- sequential writes; first one checks minimum latency ----
        check("lat_ready", {awready, wready}, 2'b11);
        awaddr = 4'h0; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        check("lat_bvalid_n", bvalid, 1'b0);
        check("lat_awready_held", awready, 1'b0);
        @(negedge clk);
        check("lat_bvalid_n1", bvalid, 1'b1);
        check("lat_reg0", reg_q[31:0], 32'h1);
        check("lat_pulse", reg_wr_pulse, 4'b0001);
        model[0] = 32'h1; exp_b++; exp_pulse[0]++;
        wait_b();
        check("lat_pulse_gone", reg_wr_pulse, 4'b0000);
        axi_write(4'h4, 32'h2, 4'hF);
        axi_write(4'h8, 32'h3, 4'hF);
        axi_write(4'hC, 32'h4, 4'hF);
        check("seq_reg_q", reg_q, 128'h00000004_00000003_00000002_00000001);
        check_counts("seq");
        for (int a = 0; a < 4; a++) axi_read(4'(a * 4), 32'(a + 1));
        axi_read(4'h6, 32'h2);   // low address bits ignored

        // ---- channel ordering ----
        axi_write(4'h4, 32'hFFFF_FFFF, 4'hF);
        send_wr(4'h4, 32'hA5A5_A5A5, 4'b0101, 3, 0);   // W leads AW
        wait_b();
        check("ord_w_first", reg_q[63:32], 32'hFFA5_FFA5);
        check_counts("ord1");
        send_wr(4'h5, 32'h5A5A_5A5A, 4'b1010, 0, 3);   // AW leads W
        wait_b();
        check("ord_aw_first", reg_q[63:32], 32'h5AA5_5AA5);
        check_counts("ord2");
        axi_write(4'hC, 32'h1234_5678, 4'b0000);        // no data change
        check("strb0_reg_q", reg_q, model_flat());
        check_counts("strb0");

        // ---- write response backpressure ----
        send_wr(4'hC, 32'hCAFE_F00D, 4'hF, 0, 0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bvalid) seen = 1;
            else @(negedge clk);
        end
        check("bp_b_arrived", seen, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("bp_b_hold%0d", i), {bvalid, awready, wready}, 3'b100);
        end
        wait_b();
        check("bp_b_reg_q", reg_q, model_flat());

        // ---- read data backpressure ----
        send_ar(4'h0, model[0]);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (rvalid) seen = 1;
            else @(negedge clk);
        end
        check("bp_r_arrived", seen, 1);
        hold = rdata;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("bp_r_hold%0d", i), {rvalid, arready, rdata}, {2'b10, hold});
        end
        wait_r();

        // ---- read/write collision on reg2 ----
        check("col_ready", {awready, wready, arready}, 3'b111);
        awaddr = 4'h8; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        check("col_arready", arready, 1'b1);
        exp_rd_q.push_back(model[2]);
        araddr = 4'h8; arvalid = 1;
        @(negedge clk);
        arvalid = 0;
        model[2] = 32'h77; exp_b++; exp_pulse[2]++;
        wait_r();
        wait_b();
        axi_read(4'h8, 32'h77);
        check_counts("col");

        // ---- reset in the middle of a write ----
        check("mid_awready", awready, 1'b1);
        awaddr = 4'h0; awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        check("mid_aw_held", awready, 1'b0);
        #2 rst = 1;
        #1;
        check("mid_rst_hs", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        check("mid_rst_reg_q", reg_q, 128'h0);
        repeat (3) @(negedge clk);
        rst = 0;
        for (int i = 0; i < 4; i++) model[i] = 0;
        repeat (5) @(negedge clk);
        check_counts("mid_no_b");
        check("mid_awready_free", awready, 1'b1);
        axi_write(4'h0, 32'h55, 4'hF);
        axi_read(4'h0, 32'h55);
        check("mid_reg_q", reg_q, {96'h0, 32'h55});
        check_counts("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
